// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: fetch-state encoding and the HALT opcode, also used by the decoder.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Opcode occupies the top OP_W bits of every instruction word.
    localparam int unsigned OP_W = 6;
    localparam logic [OP_W-1:0] OP_HALT = 6'h3F;

    function automatic logic is_halt_op(input logic [OP_W-1:0] op);
        return op == OP_HALT;
    endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: jump target, PC-relative branch target or sequential increment.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; the caller decides whether the result is loaded (stall/halt).
module pc_next #(
    parameter int N      = 8,
    parameter int AddrSz = 6
) (
    input  logic [AddrSz-1:0] pc,
    input  logic [AddrSz-1:0] ir_pc,
    input  logic              jump_en,
    input  logic [AddrSz-1:0] jump_addr,
    input  logic              branch_en,
    input  logic [N-1:0]      branch_offset,
    output logic [AddrSz-1:0] next_pc
);

    // Sign-extend first, then truncate, so a wide offset still wraps modulo 2^AddrSz.
    logic [AddrSz-1:0] offset_trunc;
    assign offset_trunc = AddrSz'({{AddrSz{branch_offset[N-1]}}, branch_offset});

    // Jump beats branch beats sequential; all sums wrap naturally at AddrSz bits.
    always_comb begin
        next_pc = pc + AddrSz'(1);
        if (jump_en) begin
            next_pc = jump_addr;
        end else if (branch_en) begin
            next_pc = ir_pc + offset_trunc;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives program memory address, registers instruction into ir with ir_pc/ir_valid.
// Latency: instruction appears in ir one edge after its address is presented; a taken redirect costs one bubble.
// Backpressure: stall freezes PC and ir; a fetched HALT opcode stops fetch until reset.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int N             = 8,
    parameter int AddrSz        = 6,
    parameter int InstructionSz = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [AddrSz-1:0]        address,
    input  logic [InstructionSz-1:0] instruction,
    input  logic                     stall,
    input  logic                     jump_en,
    input  logic [AddrSz-1:0]        jump_addr,
    input  logic                     branch_en,
    input  logic [N-1:0]             branch_offset,
    output logic [InstructionSz-1:0] ir,
    output logic [AddrSz-1:0]        ir_pc,
    output logic                     ir_valid,
    output logic                     halted
);

    fetch_state_t      state;
    logic [AddrSz-1:0] pc;
    logic [AddrSz-1:0] target;
    logic              halt_seen;

    assign address   = pc;
    assign halt_seen = ir_valid && is_halt_op(ir[InstructionSz-1 -: OP_W]);

    pc_next #(
        .N      (N),
        .AddrSz (AddrSz)
    ) u_pc_next (
        .pc            (pc),
        .ir_pc         (ir_pc),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .next_pc       (target)
    );

    // Fetch FSM: one INIT cycle, then RUN with stall > halt > jump > branch > sequential; HALT exits only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            pc       <= '0;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    pc       <= '0;
                    ir_valid <= 1'b0;
                    halted   <= 1'b0;
                    state    <= RUN;
                end
                RUN: begin
                    if (stall) begin
                        // Everything holds; redirect requests are dropped this cycle.
                    end else if (halt_seen) begin
                        ir_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else begin
                        // On a redirect the capture still happens but is flushed via ir_valid.
                        ir       <= instruction;
                        ir_pc    <= pc;
                        ir_valid <= !(jump_en || branch_en);
                        pc       <= target;
                    end
                end
                HALT: begin
                    ir_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural program memory and hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge; inputs changed at the same point.
// Backpressure: stall, redirects, HALT and async reset pulses are driven directly.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic [5:0]  address;
    logic [23:0] instruction;
    logic        stall;
    logic        jump_en;
    logic [5:0]  jump_addr;
    logic        branch_en;
    logic [7:0]  branch_offset;
    logic [23:0] ir;
    logic [5:0]  ir_pc;
    logic        ir_valid;
    logic        halted;

    logic [23:0] mem [64];
    int          nvec;
    int          nmis;

    instruction_fetch #(.N(8), .AddrSz(6), .InstructionSz(24)) dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .instruction   (instruction),
        .stall         (stall),
        .jump_en       (jump_en),
        .jump_addr     (jump_addr),
        .branch_en     (branch_en),
        .branch_offset (branch_offset),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .halted        (halted)
    );

    assign instruction = mem[address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected word at address a of the program image below.
    function automatic logic [23:0] word(input int a);
        logic [23:0] w;
        w = (a == 5) ? {6'h3F, 18'd5} : {6'h01, 18'(a)};
        return w;
    endfunction

    task automatic expect_fetch(input string tag, input logic v, input int pcv, input int addr);
        check({tag, ".valid"}, 32'(ir_valid), 32'(v));
        check({tag, ".addr"}, 32'(address), 32'(addr));
        check({tag, ".halted"}, 32'(halted), 32'd0);
        if (v) begin
            check({tag, ".ir_pc"}, 32'(ir_pc), 32'(pcv));
            check({tag, ".ir"}, 32'(ir), 32'(word(pcv)));
        end
    endtask

    task automatic expect_zero(input string tag);
        check({tag, ".addr"}, 32'(address), 32'd0);
        check({tag, ".ir"}, 32'(ir), 32'd0);
        check({tag, ".ir_pc"}, 32'(ir_pc), 32'd0);
        check({tag, ".valid"}, 32'(ir_valid), 32'd0);
        check({tag, ".halted"}, 32'(halted), 32'd0);
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        for (int i = 0; i < 64; i++) mem[i] = {6'h01, 18'(i)};
        mem[5] = {6'h3F, 18'd5};
        stall = 0; jump_en = 0; jump_addr = '0; branch_en = 0; branch_offset = '0;
        reset = 1'b1;
        #2;
        expect_zero("reset");
        #1 reset = 1'b0;

        // First edge leaves INIT without capturing; second edge captures address 0.
        tick(); expect_fetch("init", 1'b0, 0, 0);
        tick(); expect_fetch("seq0", 1'b1, 0, 1);
        tick(); expect_fetch("seq1", 1'b1, 1, 2);
        tick(); expect_fetch("seq2", 1'b1, 2, 3);

        // Stall three cycles at ir_pc=2; a concurrent jump must be ignored.
        stall = 1; jump_en = 1; jump_addr = 6'd40;
        for (int k = 0; k < 3; k++) begin
            tick(); expect_fetch("stall", 1'b1, 2, 3);
        end
        stall = 0; jump_en = 0;
        tick(); expect_fetch("unstall", 1'b1, 3, 4);
        tick(); expect_fetch("seq4", 1'b1, 4, 5);

        // Jump to 10 from ir_pc=4: one bubble, then 10.
        jump_en = 1; jump_addr = 6'd10;
        tick(); expect_fetch("jmp_bub", 1'b0, 0, 10);
        jump_en = 0;
        tick(); expect_fetch("jmp_tgt", 1'b1, 10, 11);

        // Return to 1, then branch -2 wraps to 63, and sequential wraps 63 -> 0.
        jump_en = 1; jump_addr = 6'd1;
        tick(); expect_fetch("jmp1_bub", 1'b0, 0, 1);
        jump_en = 0;
        tick(); expect_fetch("jmp1_tgt", 1'b1, 1, 2);
        branch_en = 1; branch_offset = 8'hFE;
        tick(); expect_fetch("br_bub", 1'b0, 0, 63);
        branch_en = 0;
        tick(); expect_fetch("br_tgt", 1'b1, 63, 0);
        tick(); expect_fetch("wrap", 1'b1, 0, 1);

        // Jump wins over branch when both are requested.
        jump_en = 1; jump_addr = 6'd7; branch_en = 1; branch_offset = 8'h02;
        tick(); expect_fetch("prio_bub", 1'b0, 0, 7);
        jump_en = 0; branch_en = 0;
        tick(); expect_fetch("prio_tgt", 1'b1, 7, 8);

        // Forward branch +2 from ir_pc=7 lands on 9; 0x7F from 9 wraps to 8.
        branch_en = 1; branch_offset = 8'h02;
        tick(); expect_fetch("brf_bub", 1'b0, 0, 9);
        branch_en = 0;
        tick(); expect_fetch("brf_tgt", 1'b1, 9, 10);
        branch_en = 1; branch_offset = 8'h7F;
        tick(); expect_fetch("brw_bub", 1'b0, 0, 8);
        branch_en = 0;

        // Walk into the HALT at address 5 via jump to 3.
        jump_en = 1; jump_addr = 6'd3;
        tick(); expect_fetch("toh_bub", 1'b0, 0, 3);
        jump_en = 0;
        tick(); expect_fetch("h3", 1'b1, 3, 4);
        tick(); expect_fetch("h4", 1'b1, 4, 5);
        tick(); expect_fetch("h5", 1'b1, 5, 6);
        // HALT in ir with a simultaneous jump: HALT wins, PC holds at 6.
        jump_en = 1; jump_addr = 6'd20; branch_en = 1; branch_offset = 8'h01;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("halt.halted", 32'(halted), 32'd1);
            check("halt.valid", 32'(ir_valid), 32'd0);
            check("halt.addr", 32'(address), 32'd6);
            check("halt.ir_pc", 32'(ir_pc), 32'd5);
            check("halt.ir", 32'(ir), 32'(word(5)));
        end
        jump_en = 0; branch_en = 0;

        // Asynchronous reset pulse between edges while halted.
        #1 reset = 1'b1;
        #1 expect_zero("rst_halt");
        #1 reset = 1'b0;
        tick(); expect_fetch("rh_init", 1'b0, 0, 0);
        tick(); expect_fetch("rh_seq0", 1'b1, 0, 1);
        tick(); expect_fetch("rh_seq1", 1'b1, 1, 2);

        // Asynchronous reset pulse while stalled.
        stall = 1;
        tick(); expect_fetch("rs_stall", 1'b1, 1, 2);
        #1 reset = 1'b1;
        #1 expect_zero("rst_stall");
        #1 reset = 1'b0; stall = 0;
        tick(); expect_fetch("rs_init", 1'b0, 0, 0);
        tick(); expect_fetch("rs_seq0", 1'b1, 0, 1);
        tick(); expect_fetch("rs_seq1", 1'b1, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
